matmul_tile_sequencer: RTL and testbench

MATMUL_TILE_SEQUENCER -- requirements
Module: matmul_tile_sequencer

---
 rtl/matmul_tile_sequencer_if.sv | 30 +++
 rtl/matmul_tile_sequencer.sv | 133 +++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_tile_sequencer_if.sv
// rtl/matmul_tile_sequencer_if.sv - core operand/result and write-back handshake bundle
interface matmul_tile_sequencer_if #(
  parameter int CW = 8
);

  logic          core_valid_o;
  logic          core_ready_i;
  logic          core_valid_i;
  logic          core_ready_o;
  logic [CW-1:0] m_idx_o;
  logic [CW-1:0] n_idx_o;
  logic [CW-1:0] k_idx_o;
  logic          c_sel_o;
  logic          halved_precision_o;
  logic          wr_valid_o;
  logic          wr_ready_i;

  modport master (
    output core_valid_o, core_ready_o, m_idx_o, n_idx_o, k_idx_o,
           c_sel_o, halved_precision_o, wr_valid_o,
    input  core_ready_i, core_valid_i, wr_ready_i
  );

  modport slave (
    input  core_valid_o, core_ready_o, m_idx_o, n_idx_o, k_idx_o,
           c_sel_o, halved_precision_o, wr_valid_o,
    output core_ready_i, core_valid_i, wr_ready_i
  );

endinterface

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - walks m/n/k tiles of a job through a matmul core, one op in flight
module matmul_tile_sequencer #(
  parameter int CW  = 8,
  parameter int OPW = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [CW-1:0]           m_tiles_i,
  input  logic [CW-1:0]           n_tiles_i,
  input  logic [CW-1:0]           k_tiles_i,
  input  logic                    halved_i,
  matmul_tile_sequencer_if.master core_if,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [OPW-1:0]          op_count_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q;
  logic [CW-1:0]  m_tiles_q, n_tiles_q, k_tiles_q;
  logic [CW-1:0]  m_idx_q, n_idx_q, k_idx_q;
  logic           c_sel_q;
  logic           halved_q;
  logic [OPW-1:0] op_count_q;

  logic op_hs, res_hs, wr_hs;
  logic last_k, last_n, last_m;
  logic zero_job;

  assign op_hs  = (state_q == S_ISSUE) & core_if.core_ready_i;
  assign res_hs = (state_q == S_WAIT)  & core_if.core_valid_i;
  assign wr_hs  = (state_q == S_WRITE) & core_if.wr_ready_i;

  // Counts are nonzero inside a running job, so count-1 never underflows here.
  assign last_k = (k_idx_q == k_tiles_q - CW'(1));
  assign last_n = (n_idx_q == n_tiles_q - CW'(1));
  assign last_m = (m_idx_q == m_tiles_q - CW'(1));

  assign zero_job = (m_tiles_i == '0) | (n_tiles_i == '0) | (k_tiles_i == '0);

  // Tile walk: k innermost accumulates through C feedback, then write-back advances n, then m.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      k_tiles_q  <= '0;
      m_idx_q    <= '0;
      n_idx_q    <= '0;
      k_idx_q    <= '0;
      c_sel_q    <= 1'b0;
      halved_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            m_tiles_q  <= m_tiles_i;
            n_tiles_q  <= n_tiles_i;
            k_tiles_q  <= k_tiles_i;
            halved_q   <= halved_i;
            m_idx_q    <= '0;
            n_idx_q    <= '0;
            k_idx_q    <= '0;
            c_sel_q    <= 1'b0;
            op_count_q <= '0;
            state_q    <= zero_job ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_hs) begin
            op_count_q <= op_count_q + OPW'(1);
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_hs) begin
            if (!last_k) begin
              k_idx_q <= k_idx_q + CW'(1);
              c_sel_q <= 1'b1;
              state_q <= S_ISSUE;
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (wr_hs) begin
            k_idx_q <= '0;
            c_sel_q <= 1'b0;
            if (last_n) begin
              n_idx_q <= '0;
              if (last_m) begin
                m_idx_q <= '0;
                state_q <= S_DONE;
              end else begin
                m_idx_q <= m_idx_q + CW'(1);
                state_q <= S_ISSUE;
              end
            end else begin
              n_idx_q <= n_idx_q + CW'(1);
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake strobes decode straight from state so they clear the same edge the state changes.
  always_comb begin
    core_if.core_valid_o       = (state_q == S_ISSUE);
    core_if.core_ready_o       = (state_q == S_WAIT);
    core_if.wr_valid_o         = (state_q == S_WRITE);
    core_if.m_idx_o            = m_idx_q;
    core_if.n_idx_o            = n_idx_q;
    core_if.k_idx_o            = k_idx_q;
    core_if.c_sel_o            = c_sel_q;
    core_if.halved_precision_o = halved_q;
    busy_o                     = (state_q != S_IDLE);
    done_o                     = (state_q == S_DONE);
    op_count_o                 = op_count_q;
  end

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - self-checking bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  m_tiles_i, n_tiles_i, k_tiles_i;
  logic        halved_i;
  logic        busy_o, done_o;
  logic [15:0] op_count_o;

  matmul_tile_sequencer_if #(.CW(8)) bus ();

  matmul_tile_sequencer #(.CW(8), .OPW(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .m_tiles_i  (m_tiles_i),
    .n_tiles_i  (n_tiles_i),
    .k_tiles_i  (k_tiles_i),
    .halved_i   (halved_i),
    .core_if    (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .op_count_o (op_count_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] m;
    logic [7:0] n;
    logic [7:0] k;
    logic       csel;
    logic       last;
  } op_t;

  // Transaction-level model: the full job is expanded into an ordered list of ops at start.
  op_t ops[$];
  int  phase     = 0;   // 0 idle, 1 running, 2 done pulse
  bit  await_res = 0;
  bit  wr_pend   = 0;
  int  wr_m = 0, wr_n = 0;
  int  exp_ops   = 0;
  bit  exp_half  = 0;
  bit  cur_last  = 0;
  bit  mon_en    = 0;
  int  dut_op_hs = 0;
  int  dut_wr_hs = 0;

  always @(negedge clk) begin
    bit  exp_cv, exp_cr, exp_wv;
    op_t cur;
    if (mon_en) begin
      exp_cv = (phase == 1) && !await_res && !wr_pend && (ops.size() > 0);
      exp_cr = (phase == 1) && await_res;
      exp_wv = (phase == 1) && wr_pend;
      chk("core_valid_o", int'(bus.core_valid_o), int'(exp_cv));
      chk("core_ready_o", int'(bus.core_ready_o), int'(exp_cr));
      chk("wr_valid_o",   int'(bus.wr_valid_o),   int'(exp_wv));
      chk("busy_o", int'(busy_o), int'(phase != 0));
      chk("done_o", int'(done_o), int'(phase == 2));
      chk("op_count_o", int'(op_count_o), exp_ops & 16'hFFFF);
      chk("halved_precision_o", int'(bus.halved_precision_o), int'(exp_half));
      if (exp_cv) begin
        chk("issue_m_idx", int'(bus.m_idx_o), int'(ops[0].m));
        chk("issue_n_idx", int'(bus.n_idx_o), int'(ops[0].n));
        chk("issue_k_idx", int'(bus.k_idx_o), int'(ops[0].k));
        chk("issue_c_sel", int'(bus.c_sel_o), int'(ops[0].csel));
      end
      if (exp_wv) begin
        chk("write_m_idx", int'(bus.m_idx_o), wr_m);
        chk("write_n_idx", int'(bus.n_idx_o), wr_n);
      end
      if (bus.core_valid_o && bus.core_ready_i) dut_op_hs++;
      if (bus.wr_valid_o && bus.wr_ready_i) dut_wr_hs++;

      if (!rst_ni) begin
        ops.delete();
        phase = 0; await_res = 0; wr_pend = 0; exp_ops = 0; exp_half = 0;
      end else begin
        case (phase)
          0: if (start_i) begin
            exp_ops  = 0;
            exp_half = halved_i;
            ops.delete();
            for (int mi = 0; mi < int'(m_tiles_i); mi++)
              for (int ni = 0; ni < int'(n_tiles_i); ni++)
                for (int ki = 0; ki < int'(k_tiles_i); ki++)
                  ops.push_back(op_t'{m: 8'(mi), n: 8'(ni), k: 8'(ki),
                                      csel: (ki != 0), last: (ki == int'(k_tiles_i) - 1)});
            phase = (ops.size() == 0) ? 2 : 1;
          end
          1: begin
            if (exp_cv && bus.core_ready_i) begin
              cur = ops.pop_front();
              exp_ops++;
              await_res = 1;
              cur_last  = cur.last;
              wr_m = int'(cur.m);
              wr_n = int'(cur.n);
            end else if (exp_cr && bus.core_valid_i) begin
              await_res = 0;
              if (cur_last) wr_pend = 1;
            end else if (exp_wv && bus.wr_ready_i) begin
              wr_pend = 0;
              if (ops.size() == 0) phase = 2;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int m, input int n, input int k, input bit h, output int lat);
    m_tiles_i = 8'(m); n_tiles_i = 8'(n); k_tiles_i = 8'(k); halved_i = h;
    dut_op_hs = 0; dut_wr_hs = 0;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 2000) begin
      tick;
      lat++;
    end
    chk("job_timeout", int'(lat < 2000), 1);
    tick;
  endtask

  int lat;
  int bound;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; halved_i = 1'b0;
    m_tiles_i = '0; n_tiles_i = '0; k_tiles_i = '0;
    bus.core_ready_i = 1'b1; bus.core_valid_i = 1'b1; bus.wr_ready_i = 1'b1;
    tick; tick;
    mon_en = 1;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_core_valid", int'(bus.core_valid_o), 0);
    chk("reset_op_count", int'(op_count_o), 0);
    rst_ni = 1'b1;
    tick;

    // 1x1x1 with immediate core and write-back
    run_job(1, 1, 1, 1'b0, lat);
    chk("j111_latency", lat, 4);
    chk("j111_op_count", int'(op_count_o), 1);
    chk("j111_writes", dut_wr_hs, 1);

    // 2x2x3 zero stalls, halved mode
    run_job(2, 2, 3, 1'b1, lat);
    chk("j223_latency", lat, 29);
    chk("j223_op_count", int'(op_count_o), 12);
    chk("j223_writes", dut_wr_hs, 4);
    chk("j223_halved_held", int'(bus.halved_precision_o), 1);

    // zero k tiles finishes immediately
    run_job(3, 2, 0, 1'b0, lat);
    chk("k0_latency", lat, 1);
    chk("k0_op_count", int'(op_count_o), 0);
    chk("k0_no_issue", dut_op_hs, 0);

    // stalls: operand ready low 5 cycles, write ready low 3 cycles
    bus.core_ready_i = 1'b0; bus.wr_ready_i = 1'b0;
    m_tiles_i = 8'd1; n_tiles_i = 8'd1; k_tiles_i = 8'd2; halved_i = 1'b0;
    dut_op_hs = 0; dut_wr_hs = 0;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_core_valid", int'(bus.core_valid_o), 1);
      chk("stall_k_idx", int'(bus.k_idx_o), 0);
      tick;
    end
    bus.core_ready_i = 1'b1;
    bound = 0;
    while (!bus.wr_valid_o && bound < 50) begin tick; bound++; end
    chk("stall_wr_reached", int'(bound < 50), 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_wr_valid", int'(bus.wr_valid_o), 1);
      chk("stall_wr_k_idx", int'(bus.k_idx_o), 1);
      tick;
    end
    bus.wr_ready_i = 1'b1;
    bound = 0;
    while (!done_o && bound < 50) begin tick; bound++; end
    chk("stall_done_reached", int'(bound < 50), 1);
    tick;
    chk("stall_op_count", int'(op_count_o), 2);
    chk("stall_op_hs", dut_op_hs, 2);
    chk("stall_writes", dut_wr_hs, 1);

    // reset during WAIT of a 2x2x2 job, then a clean rerun
    m_tiles_i = 8'd2; n_tiles_i = 8'd2; k_tiles_i = 8'd2; halved_i = 1'b1;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    bound = 0;
    while (!bus.core_ready_o && bound < 50) begin tick; bound++; end
    chk("rst_wait_reached", int'(bound < 50), 1);
    rst_ni = 1'b0;
    tick;
    rst_ni = 1'b1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_core_ready", int'(bus.core_ready_o), 0);
    chk("midrst_halved", int'(bus.halved_precision_o), 0);
    chk("midrst_op_count", int'(op_count_o), 0);
    tick;
    run_job(2, 2, 2, 1'b0, lat);
    chk("j222_op_count", int'(op_count_o), 8);
    chk("j222_latency", lat, 21);

    // start in WAIT and DONE ignored, config changed mid-job
    m_tiles_i = 8'd2; n_tiles_i = 8'd1; k_tiles_i = 8'd2; halved_i = 1'b1;
    dut_op_hs = 0;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    m_tiles_i = 8'd3; n_tiles_i = 8'd3; k_tiles_i = 8'd3; halved_i = 1'b0;
    bound = 0;
    while (!bus.core_ready_o && bound < 50) begin tick; bound++; end
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    bound = 0;
    while (!done_o && bound < 100) begin tick; bound++; end
    chk("cfg_done_reached", int'(bound < 100), 1);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick; tick;
    chk("cfg_idle_after", int'(busy_o), 0);
    chk("cfg_op_count", int'(op_count_o), 4);
    chk("cfg_op_hs", dut_op_hs, 4);
    chk("cfg_halved_held", int'(bus.halved_precision_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
